rd_data_unpacker: RTL and testbench
===================================

Name: rd_data_unpacker

Overview:
- Read-side width converter for the frame-buffer path.
- Accepts 128-bit words returned by DDR reads and emits them as 16-bit pixels toward the HDMI/video timing logic.
- Buffers up to DEPTH words in flops and presents pixels first-word-fall-through, i.e. prefetch style.
- Single clock domain; the DDR-clock to pixel-clock crossing is handled upstream.

Parameters:
IN_WIDTH, 128, input word width; must equal OUT_WIDTH*LANES
OUT_WIDTH, 16, output pixel width
LANES, 8, pixels per input word (IN_WIDTH/OUT_WIDTH); power of 2
DEPTH, 4, buffered input words; power of 2, range 2..16
LVL_W, 8, width of level output; must hold DEPTH*LANES

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous flush, active high
in_en  in  1  write strobe; word accepted when in_en && in_rdy
in_data  in  IN_WIDTH  DDR read word; lane 0 = bits [15:0]
in_rdy  out  1  space for at least one word (word count < DEPTH)
out_en  in  1  pixel consume request; effective when out_vld
out_vld  out  1  out_data holds a valid pixel
out_data  out  OUT_WIDTH  current pixel
level  out  LVL_W  pixels available = word_count*LANES - lane
ovf_err  out  1  sticky: in_en seen while !in_rdy
udf_err  out  1  sticky: out_en seen while !out_vld

Behaviour:
- Reset (rst_n low, asynchronous) and clear (synchronous):
  - wr_ptr, rd_ptr, word_count and lane go to 0.
  - Both error flags go to 0.
  - Outputs: in_rdy=1, out_vld=0, out_data=0, level=0. clear has priority over in_en/out_en in the same cycle.
- Storage: DEPTH x IN_WIDTH flop array; log2(DEPTH)-bit pointers that wrap naturally.
- word_count ranges 0..DEPTH and is (log2(DEPTH)+1) bits wide.
- Push: in_en && in_rdy writes mem[wr_ptr], then wr_ptr+1 and word_count+1.
- in_rdy = (word_count != DEPTH).
  - Decoded from registers only; it does not account for a same-cycle pop, so there is no combinational path from out_en.
- Lane counter: 0..LANES-1.
- out_vld = (word_count != 0).
- out_data = mem[rd_ptr][lane*OUT_WIDTH +: OUT_WIDTH] when out_vld, else 0.
  - Combinational mux from registers.
- Consume: out_en && out_vld.
  - If lane != LANES-1: lane+1.
  - If lane == LANES-1: lane wraps to 0, rd_ptr+1, word_count-1 (pop).
- Latency: a word pushed at edge N makes out_vld=1 and presents lane 0 after edge N when the buffer was empty (one cycle, FWFT).
- Pixel throughput: 1 pixel/clk is sustained indefinitely when one word arrives per LANES clocks.
- Simultaneous push and pop in the same cycle:
  - word_count is unchanged.
  - Both pointers advance.
  - If the buffer was full, the push is rejected (in_rdy=0) while the pop still completes.
- Overflow: in_en with in_rdy=0 → the word is dropped, the memory and pointers are unchanged, and ovf_err is set.
- Underflow: out_en with out_vld=0 → no state change; udf_err is set.
- Sticky error flags clear only by reset or clear.
- level is registered and updated every cycle from the next-state word_count and lane. It is exact, including simultaneous push and pop.
- No partial-word flush: a clear mid-word discards the remaining lanes of that word.

Test Plan:
1. Reset, then idle → in_rdy=1, out_vld=0, level=0, out_data=0, both error flags 0.
2. Push 128'h0007_0006_0005_0004_0003_0002_0001_0000, then hold out_en=1 → out_vld is high one cycle after the push. out_data sequence is 0000,0001,…,0007 on consecutive cycles. level counts 8,7,…,1,0. out_vld drops after the 8th pixel.
3. Push 4 words with out_en=0 (DEPTH=4), then a 5th in_en → in_rdy=0 after the 4th push. The 5th word is dropped and ovf_err=1. level=32. Draining 32 pixels yields words 1–4 in order.
4. Full buffer, lane=7, out_en=1 and in_en=1 in the same cycle → the pop completes, the push is rejected, ovf_err=1, word_count=3. in_rdy=1 on the next cycle.
5. Continuous streaming: one word per 8 clocks, out_en tied high for 1000 cycles → after the first pixel, out_vld never drops. No errors occur. Pixel values are an incrementing 16-bit sequence across the rd_ptr wrap.
6. Mid-stream: lane=3 with 2 words buffered, then pulse clear; separately, out_en while empty → after clear, out_vld=0, level=0, pointers 0. out_en while empty sets only udf_err. A subsequent push restarts at lane 0. Deasserting rst_n asynchronously mid-push forces all outputs to reset values without waiting for a clk edge.

Source files
------------

// File: rtl/rd_data_unpacker.sv
// Read-side width converter: buffers wide DDR read words and presents them
// first-word-fall-through as a stream of narrow pixels, lane 0 first.
module rd_data_unpacker #(
  parameter int IN_WIDTH  = 128,
  parameter int OUT_WIDTH = 16,
  parameter int LANES     = 8,
  parameter int DEPTH     = 4,
  parameter int LVL_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clear,
  input  logic                 i_in_en,
  input  logic [IN_WIDTH-1:0]  i_in_data,
  output logic                 o_in_rdy,
  input  logic                 i_out_en,
  output logic                 o_out_vld,
  output logic [OUT_WIDTH-1:0] o_out_data,
  output logic [LVL_W-1:0]     o_level,
  output logic                 o_ovf_err,
  output logic                 o_udf_err
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LANE_W = $clog2(LANES);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_EMPTY = CNT_W'(0);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  logic [IN_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [LANE_W-1:0]   r_lane;
  logic [LVL_W-1:0]    r_level;
  logic                r_ovf;
  logic                r_udf;

  logic                w_in_rdy;
  logic                w_out_vld;
  logic                w_push;
  logic                w_take;
  logic                w_pop;
  logic [CNT_W-1:0]    w_count_nxt;
  logic [LANE_W-1:0]   w_lane_nxt;
  logic [LVL_W-1:0]    w_level_nxt;
  logic [IN_WIDTH-1:0] w_head;

  // Handshake status comes from registers only, so no out_en -> in_rdy path.
  assign w_in_rdy  = (r_count != CNT_FULL);
  assign w_out_vld = (r_count != CNT_EMPTY);
  assign w_push    = i_in_en & w_in_rdy;
  assign w_take    = i_out_en & w_out_vld;
  assign w_pop     = w_take & (r_lane == LAST_LANE);
  assign w_head    = r_mem[r_rd_ptr];

  // Next-state occupancy, lane and pixel level
  always_comb begin
    w_count_nxt = r_count;
    w_lane_nxt  = r_lane;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
    if (w_take) begin
      if (r_lane == LAST_LANE) begin
        w_lane_nxt = LANE_W'(0);
      end else begin
        w_lane_nxt = r_lane + LANE_W'(1);
      end
    end else begin
      w_lane_nxt = r_lane;
    end
    w_level_nxt = LVL_W'(w_count_nxt) * LVL_W'(LANES) - LVL_W'(w_lane_nxt);
  end

  // Word storage; only accepted pushes write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_in_data;
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

  // Pointers, occupancy, lane and level; clear wins over any transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= PTR_W'(0);
      r_rd_ptr <= PTR_W'(0);
      r_count  <= CNT_W'(0);
      r_lane   <= LANE_W'(0);
      r_level  <= LVL_W'(0);
    end else if (i_clear) begin
      r_wr_ptr <= PTR_W'(0);
      r_rd_ptr <= PTR_W'(0);
      r_count  <= CNT_W'(0);
      r_lane   <= LANE_W'(0);
      r_level  <= LVL_W'(0);
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      r_count <= w_count_nxt;
      r_lane  <= w_lane_nxt;
      r_level <= w_level_nxt;
    end
  end

  // Sticky protocol-violation flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else if (i_clear) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= r_ovf | (i_in_en & ~w_in_rdy);
      r_udf <= r_udf | (i_out_en & ~w_out_vld);
    end
  end

  // Current pixel: lane select of the head word, zero while empty
  always_comb begin
    o_out_data = '0;
    if (w_out_vld) begin
      o_out_data = w_head[r_lane*OUT_WIDTH +: OUT_WIDTH];
    end else begin
      o_out_data = '0;
    end
  end

  assign o_in_rdy  = w_in_rdy;
  assign o_out_vld = w_out_vld;
  assign o_level   = r_level;
  assign o_ovf_err = r_ovf;
  assign o_udf_err = r_udf;

endmodule

// File: tb/tb_rd_data_unpacker.sv
// Bench for rd_data_unpacker: directed stimulus queues expected pixels, a
// negedge monitor pops and compares every consumed pixel.
module tb_rd_data_unpacker;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_clear;
  logic         i_in_en;
  logic [127:0] i_in_data;
  logic         o_in_rdy;
  logic         i_out_en;
  logic         o_out_vld;
  logic [15:0]  o_out_data;
  logic [7:0]   o_level;
  logic         o_ovf_err;
  logic         o_udf_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  rd_data_unpacker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (i_clear),
    .i_in_en    (i_in_en),
    .i_in_data  (i_in_data),
    .o_in_rdy   (o_in_rdy),
    .i_out_en   (i_out_en),
    .o_out_vld  (o_out_vld),
    .o_out_data (o_out_data),
    .o_level    (o_level),
    .o_ovf_err  (o_ovf_err),
    .o_udf_err  (o_udf_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] make_word(input logic [15:0] base);
    logic [127:0] w;
    w = 128'd0;
    for (int j = 0; j < 8; j++) w[j*16 +: 16] = base + 16'(j);
    return w;
  endfunction

  task automatic push_exp(input logic [127:0] w);
    for (int j = 0; j < 8; j++) exp_q.push_back(w[j*16 +: 16]);
  endtask

  // Scoreboard monitor: every pixel consumed at the coming edge must match
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst_n && i_out_en && o_out_vld) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pixel_extra: got %0h expected none", o_out_data);
      end else begin
        e = exp_q.pop_front();
        check("pixel", {112'd0, o_out_data}, {112'd0, e});
      end
    end
  end

  initial begin
    logic [127:0] w;
    logic [15:0]  pix;
    int           drops;

    rst_n = 1'b0; i_clear = 1'b0; i_in_en = 1'b0; i_out_en = 1'b0; i_in_data = 128'd0;
    #12 rst_n = 1'b1;
    step();

    // 1: reset state
    check("rst_in_rdy", o_in_rdy, 1'b1);
    check("rst_out_vld", o_out_vld, 1'b0);
    check("rst_level", o_level, 8'd0);
    check("rst_out_data", o_out_data, 16'd0);
    check("rst_ovf", o_ovf_err, 1'b0);
    check("rst_udf", o_udf_err, 1'b0);

    // 2: single word, FWFT, drain with level countdown
    w = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
    i_in_data = w; i_in_en = 1'b1; push_exp(w);
    step();
    i_in_en = 1'b0;
    check("t2_vld_after_push", o_out_vld, 1'b1);
    check("t2_first_pixel", o_out_data, 16'h0000);
    i_out_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t2_level", o_level, 8'(8 - i));
      step();
    end
    i_out_en = 1'b0;
    check("t2_vld_drop", o_out_vld, 1'b0);
    check("t2_level_end", o_level, 8'd0);

    // 3: fill to DEPTH, overflow attempt dropped
    for (int k = 0; k < 4; k++) begin
      w = make_word(16'h0100 * 16'(k + 1));
      check("t3_in_rdy_fill", o_in_rdy, 1'b1);
      i_in_data = w; i_in_en = 1'b1; push_exp(w);
      step();
    end
    i_in_en = 1'b0;
    check("t3_in_rdy_full", o_in_rdy, 1'b0);
    check("t3_level_full", o_level, 8'd32);
    i_in_data = {8{16'hDEAD}}; i_in_en = 1'b1;
    check("t3_ovf_before", o_ovf_err, 1'b0);
    step();
    i_in_en = 1'b0;
    check("t3_ovf_set", o_ovf_err, 1'b1);
    check("t3_level_kept", o_level, 8'd32);

    // 4: advance to lane 7, then pop and rejected push in the same cycle
    i_out_en = 1'b1;
    for (int i = 0; i < 7; i++) step();
    check("t4_level_lane7", o_level, 8'd25);
    i_in_data = {8{16'hBEEF}}; i_in_en = 1'b1;
    step();
    i_in_en = 1'b0;
    check("t4_level_after_pop", o_level, 8'd24);
    check("t4_in_rdy", o_in_rdy, 1'b1);
    check("t4_ovf_sticky", o_ovf_err, 1'b1);
    for (int i = 0; i < 24; i++) step();
    i_out_en = 1'b0;
    check("t4_drained_vld", o_out_vld, 1'b0);
    check("t4_drained_level", o_level, 8'd0);
    check("t4_queue_empty", 128'(exp_q.size()), 128'd0);
    check("t4_udf_clean", o_udf_err, 1'b0);
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    check("t4_clear_ovf", o_ovf_err, 1'b0);

    // 5: one word per 8 clocks with out_en held high
    pix = 16'hFF00;
    drops = 0;
    for (int n = 0; n < 125; n++) begin
      for (int c = 0; c < 8; c++) begin
        if (c == 0) begin
          w = make_word(pix);
          pix = pix + 16'd8;
          i_in_data = w; i_in_en = 1'b1; push_exp(w);
        end
        step();
        i_in_en = 1'b0;
        i_out_en = 1'b1;
        if (!o_out_vld) drops++;
      end
    end
    step();
    i_out_en = 1'b0;
    check("t5_vld_drops", 128'(drops), 128'd0);
    check("t5_vld_end", o_out_vld, 1'b0);
    check("t5_ovf", o_ovf_err, 1'b0);
    check("t5_udf", o_udf_err, 1'b0);
    check("t5_queue_empty", 128'(exp_q.size()), 128'd0);

    // 6: clear mid-word (with a competing push), underflow, restart
    for (int k = 0; k < 2; k++) begin
      w = make_word(16'h2000 + 16'h1000 * 16'(k));
      i_in_data = w; i_in_en = 1'b1; push_exp(w);
      step();
    end
    i_in_en = 1'b0;
    i_out_en = 1'b1;
    for (int i = 0; i < 3; i++) step();
    i_out_en = 1'b0;
    check("t6_level_lane3", o_level, 8'd13);
    i_clear = 1'b1; i_in_en = 1'b1; i_in_data = {8{16'hCAFE}};
    step();
    i_clear = 1'b0; i_in_en = 1'b0;
    exp_q.delete();
    check("t6_clear_vld", o_out_vld, 1'b0);
    check("t6_clear_level", o_level, 8'd0);
    check("t6_clear_in_rdy", o_in_rdy, 1'b1);
    check("t6_clear_data", o_out_data, 16'd0);
    i_out_en = 1'b1;
    step();
    i_out_en = 1'b0;
    check("t6_udf_set", o_udf_err, 1'b1);
    check("t6_udf_no_ovf", o_ovf_err, 1'b0);
    check("t6_udf_level", o_level, 8'd0);
    w = make_word(16'h4000);
    i_in_data = w; i_in_en = 1'b1; push_exp(w);
    step();
    i_in_en = 1'b0;
    check("t6_restart_lane0", o_out_data, 16'h4000);
    check("t6_restart_level", o_level, 8'd8);
    i_out_en = 1'b1;
    for (int i = 0; i < 8; i++) step();
    i_out_en = 1'b0;
    check("t6_restart_drained", o_out_vld, 1'b0);

    // async reset mid-push, checked between clock edges
    w = make_word(16'h5000);
    i_in_data = w; i_in_en = 1'b1;
    step();
    i_in_data = make_word(16'h6000);
    check("t6_pre_reset_vld", o_out_vld, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_vld", o_out_vld, 1'b0);
    check("t6_async_level", o_level, 8'd0);
    check("t6_async_in_rdy", o_in_rdy, 1'b1);
    check("t6_async_data", o_out_data, 16'd0);
    check("t6_async_udf", o_udf_err, 1'b0);
    exp_q.delete();
    i_in_en = 1'b0;
    #3 rst_n = 1'b1;
    step();
    check("t6_post_reset_vld", o_out_vld, 1'b0);
    check("final_queue_empty", 128'(exp_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
